// File: rtl/burst_rep_arbiter.sv
// Two-requester round-robin arbiter granting fixed BURST_LEN-beat bursts; grant registered on the sampling edge.
// No backpressure: req is only looked at in IDLE, a granted burst always runs to completion.
module burst_rep_arbiter #(
    parameter int BURST_LEN = 3,
    parameter int CW        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    output logic [1:0]    gnt,
    output logic          bvalid,
    output logic          last,
    output logic [CW-1:0] beat_cnt,
    output logic          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] beat_q, beat_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          bvalid_q, bvalid_d;
    logic          last_q, last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
            bvalid_q     <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            bvalid_q     <= bvalid_d;
            last_q       <= last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d      = BURST;
                    beat_d       = '0;
                    // With both requesting, the one that did not win last time goes next.
                    owner_d      = (req == 2'b11) ? ~last_owner_q : req[1];
                    last_owner_d = owner_d;
                end
            end
            BURST: begin
                if (beat_q >= LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Outputs are computed from next state so they land in flops alongside it.
    always_comb begin
        gnt_d  = 2'b00;
        last_d = 1'b0;
        if (state_d == BURST) begin
            gnt_d[owner_d] = 1'b1;
            last_d         = (beat_d == LAST_BEAT);
        end
        bvalid_d = |gnt_d;
    end

    assign gnt      = gnt_q;
    assign bvalid   = bvalid_q;
    assign last     = last_q;
    assign beat_cnt = beat_q;
    assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_burst_rep_arbiter.sv
module tb_burst_rep_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req3, req1;
    logic [1:0] gnt3, gnt1;
    logic       bv3, bv1, last3, last1, busy3, busy1;
    logic [3:0] beat3;
    logic [0:0] beat1;
    logic [1:0] pend3;
    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    burst_rep_arbiter #(.BURST_LEN(3), .CW(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .gnt(gnt3), .bvalid(bv3),
        .last(last3), .beat_cnt(beat3), .busy(busy3)
    );

    burst_rep_arbiter #(.BURST_LEN(1), .CW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .gnt(gnt1), .bvalid(bv1),
        .last(last1), .beat_cnt(beat1), .busy(busy1)
    );

    function automatic logic [8:0] ex(input logic [1:0] g, input logic l, input logic [3:0] b);
        return {g, |g, l, b, |g};
    endfunction

    function automatic logic [8:0] obs3();
        return {gnt3, bv3, last3, beat3, busy3};
    endfunction

    function automatic logic [8:0] obs1();
        return {gnt1, bv1, last1, 3'b000, beat1, busy1};
    endfunction

    // Beats still owed for a request accepted in IDLE (BURST_LEN = 3).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend3 <= 2'd0;
        else if (!bv3 && req3 != 2'b00) pend3 <= 2'd3;
        else if (pend3 != 2'd0) pend3 <= pend3 - 2'd1;
    end

    a_latency: assert property (@(posedge clk) disable iff (!rst_n) (pend3 != 2'd0) |-> bv3)
        else begin errors++; $display("FAIL a_latency: bvalid=%b while %0d beats owed", bv3, pend3); end
    a_onehot3: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt3))
        else begin errors++; $display("FAIL a_onehot3: gnt=%b", gnt3); end
    a_hold3: assert property (@(posedge clk) disable iff (!rst_n) (bv3 && !last3) |=> (gnt3 == $past(gnt3)))
        else begin errors++; $display("FAIL a_hold3: gnt=%b changed mid-burst", gnt3); end
    a_onehot1: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt1))
        else begin errors++; $display("FAIL a_onehot1: gnt=%b", gnt1); end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req3  = 2'b00;
        req1  = 2'b00;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        req3 = 2'b11;
        req1 = 2'b11;
        #1 rst_n = 1'b0;
        #2;
        got = obs3(); checks++;
        if (got !== 9'b0) begin errors++; $display("FAIL reset_async3 got=%b exp=%b", got, 9'b0); end
        got = obs1(); checks++;
        if (got !== 9'b0) begin errors++; $display("FAIL reset_async1 got=%b exp=%b", got, 9'b0); end
        @(posedge clk); @(negedge clk);
        got = obs3(); checks++;
        if (got !== 9'b0) begin errors++; $display("FAIL reset_held3 got=%b exp=%b", got, 9'b0); end
        req3 = 2'b00;
        req1 = 2'b00;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        got = obs3(); checks++;
        if (got !== 9'b0) begin errors++; $display("FAIL idle_noreq3 got=%b exp=%b", got, 9'b0); end
        got = obs1(); checks++;
        if (got !== 9'b0) begin errors++; $display("FAIL idle_noreq1 got=%b exp=%b", got, 9'b0); end
    endtask

    task automatic test_single();
        logic [1:0] stim [5];
        logic [8:0] expv [5];
        logic [8:0] got, want;
        do_reset();
        stim = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        expv = '{ex(2'b01, 1'b0, 4'd0), ex(2'b01, 1'b0, 4'd1), ex(2'b01, 1'b1, 4'd2),
                 9'b0, 9'b0};
        for (int i = 0; i < 5; i++) begin
            req3 = stim[i];
            sb.push_back(expv[i]);
            @(posedge clk); @(negedge clk);
            want = sb.pop_front();
            got  = obs3(); checks++;
            if (got !== want) begin errors++; $display("FAIL single[%0d] got=%b exp=%b", i, got, want); end
        end
    endtask

    task automatic test_alternate();
        logic [8:0] got, want;
        logic [1:0] g;
        int         p;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req3 = 2'b11;
            p = i % 4;
            g = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
            sb.push_back((p == 3) ? 9'b0 : ex(g, p == 2, 4'(p)));
            @(posedge clk); @(negedge clk);
            want = sb.pop_front();
            got  = obs3(); checks++;
            if (got !== want) begin errors++; $display("FAIL alternate[%0d] got=%b exp=%b", i, got, want); end
        end
        req3 = 2'b00;
    endtask

    task automatic test_drop();
        logic [1:0] stim [8];
        logic [8:0] expv [8];
        logic [8:0] got, want;
        do_reset();
        stim = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        expv = '{ex(2'b01, 1'b0, 4'd0), ex(2'b01, 1'b0, 4'd1), ex(2'b01, 1'b1, 4'd2), 9'b0,
                 ex(2'b10, 1'b0, 4'd0), ex(2'b10, 1'b0, 4'd1), ex(2'b10, 1'b1, 4'd2), 9'b0};
        for (int i = 0; i < 8; i++) begin
            req3 = stim[i];
            sb.push_back(expv[i]);
            @(posedge clk); @(negedge clk);
            want = sb.pop_front();
            got  = obs3(); checks++;
            if (got !== want) begin errors++; $display("FAIL drop[%0d] got=%b exp=%b", i, got, want); end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] stim [6];
        logic [8:0] expv [6];
        logic [8:0] got, want;
        do_reset();
        stim = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        expv = '{ex(2'b01, 1'b0, 4'd0), ex(2'b01, 1'b0, 4'd1),
                 ex(2'b10, 1'b0, 4'd0), ex(2'b10, 1'b0, 4'd1), ex(2'b10, 1'b1, 4'd2), 9'b0};
        for (int i = 0; i < 2; i++) begin
            req3 = stim[i];
            sb.push_back(expv[i]);
            @(posedge clk); @(negedge clk);
            want = sb.pop_front();
            got  = obs3(); checks++;
            if (got !== want) begin errors++; $display("FAIL resetmid_pre[%0d] got=%b exp=%b", i, got, want); end
        end
        #2 rst_n = 1'b0;
        #1;
        got = obs3(); checks++;
        if (got !== 9'b0) begin errors++; $display("FAIL resetmid_async got=%b exp=%b", got, 9'b0); end
        req3 = 2'b10;
        @(posedge clk); @(negedge clk);
        got = obs3(); checks++;
        if (got !== 9'b0) begin errors++; $display("FAIL resetmid_held got=%b exp=%b", got, 9'b0); end
        rst_n = 1'b1;
        #1;
        got = obs3(); checks++;
        if (got !== 9'b0) begin errors++; $display("FAIL resetmid_release got=%b exp=%b", got, 9'b0); end
        for (int i = 2; i < 6; i++) begin
            req3 = stim[i];
            sb.push_back(expv[i]);
            @(posedge clk); @(negedge clk);
            want = sb.pop_front();
            got  = obs3(); checks++;
            if (got !== want) begin errors++; $display("FAIL resetmid_post[%0d] got=%b exp=%b", i, got, want); end
        end
    endtask

    task automatic test_len1();
        logic [1:0] stim [7];
        logic [8:0] expv [7];
        logic [8:0] got, want;
        do_reset();
        stim = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00};
        expv = '{ex(2'b10, 1'b1, 4'd0), 9'b0, 9'b0,
                 ex(2'b01, 1'b1, 4'd0), 9'b0, ex(2'b10, 1'b1, 4'd0), 9'b0};
        for (int i = 0; i < 7; i++) begin
            req1 = stim[i];
            sb.push_back(expv[i]);
            @(posedge clk); @(negedge clk);
            want = sb.pop_front();
            got  = obs1(); checks++;
            if (got !== want) begin errors++; $display("FAIL len1[%0d] got=%b exp=%b", i, got, want); end
        end
        req1 = 2'b00;
    endtask

    initial begin
        req3 = 2'b00;
        req1 = 2'b00;
        test_reset();
        test_single();
        test_alternate();
        test_drop();
        test_reset_mid();
        test_len1();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
